// File: rtl/brwm_arb_pkg.sv
// Shared types and default parameters for the frame-buffer (BRWM) arbiter.
//   arb_state_t   : grant owner (IDLE, camera, Grayscaler)
//   DEF_*         : default widths and burst limit used by brwm_arbiter
package brwm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CAM  = 2'b01,
        ST_GS   = 2'b10
    } arb_state_t;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/arb_burst_ctr.sv
// Per-grant access counter for the BRWM arbiter.
//   clk, rst_n  : system clock, async active-low reset
//   i_clear     : clear on grant change (has priority over i_inc)
//   i_inc       : one access performed this cycle
//   o_at_limit  : count has reached MAX_BURST-1 (saturates there)
module arb_burst_ctr #(
    parameter int MAX_BURST = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam int CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Saturating keeps at_limit asserted for an uncontested owner, so a
    // late-arriving competitor is served after the very next access.
    assign o_at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/brwm_arbiter.sv
// Round-robin arbiter for the single-port frame-buffer memory, shared by the
// camera pixel writer and the Grayscaler pixel reader, with bounded bursts.
//   clk, rst_n                      : system clock, async active-low reset
//   cam_req/cam_addr/cam_wdata      : camera write request and payload
//   cam_gnt                         : camera owns the memory port
//   gs_req/gs_addr                  : Grayscaler read request and address
//   gs_gnt, gs_rdata, gs_rvalid     : Grayscaler grant, read data, data valid
//   mem_en/mem_we/mem_addr/mem_wdata: memory port strobe and payload
//   mem_rdata                       : memory read data (1-cycle sync read)
//
// state | meaning
// IDLE  | nobody owns the port, no access
// CAM   | camera owns the port, writes whenever cam_req=1
// GS    | Grayscaler owns the port, reads whenever gs_req=1
module brwm_arbiter
    import brwm_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    output logic              cam_gnt,
    input  logic              gs_req,
    input  logic [ADDR_W-1:0] gs_addr,
    output logic              gs_gnt,
    output logic [DATA_W-1:0] gs_rdata,
    output logic              gs_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_cam;
    logic       r_gs_rvalid;
    logic       w_cam_acc;
    logic       w_gs_acc;
    logic       w_at_limit;
    logic       w_switch;

    assign w_cam_acc = (r_state == ST_CAM) && cam_req;
    assign w_gs_acc  = (r_state == ST_GS)  && gs_req;
    assign w_switch  = (w_state_nxt != r_state);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cam_req && gs_req) begin
                    w_state_nxt = r_last_cam ? ST_GS : ST_CAM;
                end else if (cam_req) begin
                    w_state_nxt = ST_CAM;
                end else if (gs_req) begin
                    w_state_nxt = ST_GS;
                end
            end
            ST_CAM: begin
                if (!cam_req) begin
                    w_state_nxt = gs_req ? ST_GS : ST_IDLE;
                end else if (w_at_limit && gs_req) begin
                    w_state_nxt = ST_GS;
                end
            end
            ST_GS: begin
                if (!gs_req) begin
                    w_state_nxt = cam_req ? ST_CAM : ST_IDLE;
                end else if (w_at_limit && cam_req) begin
                    w_state_nxt = ST_CAM;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_cam  <= 1'b0;
            r_gs_rvalid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gs_rvalid <= w_gs_acc;
            if (w_switch && (r_state == ST_CAM)) begin
                r_last_cam <= 1'b1;
            end else if (w_switch && (r_state == ST_GS)) begin
                r_last_cam <= 1'b0;
            end
        end
    end

    arb_burst_ctr #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_switch),
        .i_inc      (w_cam_acc | w_gs_acc),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cam_acc) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cam_addr;
            mem_wdata = cam_wdata;
        end else if (w_gs_acc) begin
            mem_en   = 1'b1;
            mem_addr = gs_addr;
        end
    end

    assign cam_gnt   = (r_state == ST_CAM);
    assign gs_gnt    = (r_state == ST_GS);
    assign gs_rvalid = r_gs_rvalid;
    assign gs_rdata  = mem_rdata;

endmodule

// File: tb/tb_brwm_arbiter.sv
// Self-checking bench for brwm_arbiter (MAX_BURST=16).
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge. Expected writes/reads are queued when stimulus is applied
// and popped when the DUT shows the access or the read-valid.
module tb_brwm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_req = 1'b0;
    logic [15:0] cam_addr = '0;
    logic [7:0]  cam_wdata = '0;
    logic        cam_gnt;
    logic        gs_req = 1'b0;
    logic [15:0] gs_addr = '0;
    logic        gs_gnt;
    logic [7:0]  gs_rdata;
    logic        gs_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] wq[$];
    logic [7:0]  rq[$];
    logic        rd_pend = 1'b0;
    logic [15:0] rd_addr = '0;
    logic        exp_rv = 1'b0;
    logic [3:0]  ho_tbl [0:11];

    always #5 clk = ~clk;

    brwm_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (8),
        .MAX_BURST (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cam_req   (cam_req),
        .cam_addr  (cam_addr),
        .cam_wdata (cam_wdata),
        .cam_gnt   (cam_gnt),
        .gs_req    (gs_req),
        .gs_addr   (gs_addr),
        .gs_gnt    (gs_gnt),
        .gs_rdata  (gs_rdata),
        .gs_rvalid (gs_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory contents as a fixed function of the address; 0x0010 -> 0xA5.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    // Advance to the drive point and present last cycle's read result.
    task automatic drive_edge();
        @(posedge clk);
        #1;
        mem_rdata = rd_pend ? mem_f(rd_addr) : 8'h00;
    endtask

    task automatic test_reset();
        cam_req = 1'b1;
        gs_req  = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        n_vec++;
        if ({cam_gnt, gs_gnt, gs_rvalid, mem_en, mem_we} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_hold: gnt=%b%b rv=%b en=%b we=%b want all 0",
                     cam_gnt, gs_gnt, gs_rvalid, mem_en, mem_we);
        end
        drive_edge();
        cam_req = 1'b0;
        gs_req  = 1'b0;
        rst_n   = 1'b1;
        #4;
        n_vec++;
        if ({cam_gnt, gs_gnt, gs_rvalid, mem_en, mem_we} !== 5'b0 ||
            mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
            n_err++;
            $display("FAIL reset_release: gnt=%b%b rv=%b en=%b we=%b addr=%h want all 0",
                     cam_gnt, gs_gnt, gs_rvalid, mem_en, mem_we, mem_addr);
        end
    endtask

    task automatic test_lone_cam();
        logic e_c, e_acc;
        int k, n_acc;
        n_acc = 0;
        for (int c = 0; c <= 42; c++) begin
            drive_edge();
            cam_req = (c <= 40);
            gs_req  = 1'b0;
            k = (c == 0) ? 0 : c - 1;
            if (c <= 40) begin
                cam_addr  = 16'h1000 + 16'(k);
                cam_wdata = 8'(k * 7 + 3);
            end
            e_c   = (c >= 1 && c <= 41);
            e_acc = e_c && cam_req;
            if (e_acc) wq.push_back({cam_addr, cam_wdata});
            #4;
            n_vec++;
            if (cam_gnt !== e_c || gs_gnt !== 1'b0) begin
                n_err++;
                $display("FAIL lone_cam_gnt c=%0d: got %b%b want %b0", c, cam_gnt, gs_gnt, e_c);
            end
            n_vec++;
            if (mem_en !== e_acc || mem_we !== e_acc) begin
                n_err++;
                $display("FAIL lone_cam_en c=%0d: en=%b we=%b want %b", c, mem_en, mem_we, e_acc);
            end
            if (mem_en && mem_we) begin
                n_vec++;
                n_acc++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL lone_cam_extra c=%0d: unexpected write addr=%h", c, mem_addr);
                end else if ({mem_addr, mem_wdata} !== wq[0]) begin
                    n_err++;
                    $display("FAIL lone_cam_wr c=%0d: got %h/%h want %h/%h", c,
                             mem_addr, mem_wdata, wq[0][23:8], wq[0][7:0]);
                    void'(wq.pop_front());
                end else begin
                    void'(wq.pop_front());
                end
            end
            rd_pend = mem_en && !mem_we;
            rd_addr = mem_addr;
            exp_rv  = 1'b0;
        end
        n_vec++;
        if (n_acc != 40 || wq.size() != 0) begin
            n_err++;
            $display("FAIL lone_cam_count: got %0d writes (%0d left) want 40", n_acc, wq.size());
        end
        wq.delete();
    endtask

    task automatic test_lone_read();
        logic e_g, e_acc;
        for (int c = 0; c <= 8; c++) begin
            drive_edge();
            cam_req = 1'b0;
            gs_req  = (c == 5 || c == 6);
            if (c == 5) gs_addr = 16'h0010;
            e_g   = (c == 6 || c == 7);
            e_acc = e_g && gs_req;
            if (e_acc) rq.push_back(mem_f(gs_addr));
            #4;
            n_vec++;
            if (gs_gnt !== e_g || cam_gnt !== 1'b0) begin
                n_err++;
                $display("FAIL lone_read_gnt c=%0d: got cam=%b gs=%b want gs=%b", c, cam_gnt, gs_gnt, e_g);
            end
            n_vec++;
            if (mem_en !== e_acc || mem_we !== 1'b0 || (e_acc && mem_addr !== 16'h0010)) begin
                n_err++;
                $display("FAIL lone_read_en c=%0d: en=%b we=%b addr=%h want en=%b we=0 addr=0010",
                         c, mem_en, mem_we, mem_addr, e_acc);
            end
            n_vec++;
            if (gs_rvalid !== exp_rv) begin
                n_err++;
                $display("FAIL lone_read_rv c=%0d: got %b want %b", c, gs_rvalid, exp_rv);
            end
            if (gs_rvalid) begin
                n_vec++;
                if (rq.size() == 0 || gs_rdata !== rq[0] || gs_rdata !== 8'hA5) begin
                    n_err++;
                    $display("FAIL lone_read_data c=%0d: got %h want a5", c, gs_rdata);
                end
                if (rq.size() != 0) void'(rq.pop_front());
            end
            exp_rv  = e_acc;
            rd_pend = mem_en && !mem_we;
            rd_addr = mem_addr;
        end
    endtask

    task automatic test_reset_mid_burst();
        drive_edge();
        cam_req   = 1'b1;
        gs_req    = 1'b0;
        cam_addr  = 16'h0AAA;
        cam_wdata = 8'h55;
        repeat (3) @(posedge clk);
        #4;
        n_vec++;
        if (cam_gnt !== 1'b1 || mem_en !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre_cam: gnt=%b en=%b want 1 1", cam_gnt, mem_en);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (cam_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_cam: gnt=%b en=%b we=%b want 0 0 0", cam_gnt, mem_en, mem_we);
        end
        @(posedge clk);
        #1;
        cam_req = 1'b0;
        gs_req  = 1'b1;
        gs_addr = 16'h0BBB;
        rst_n   = 1'b1;
        @(posedge clk);
        #4;
        n_vec++;
        if (gs_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_pre_gs: gnt=%b en=%b we=%b want 1 1 0", gs_gnt, mem_en, mem_we);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (gs_rvalid !== 1'b0 || gs_gnt !== 1'b0 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_rv_drop: rv=%b gnt=%b en=%b want 0 0 0", gs_rvalid, gs_gnt, mem_en);
        end
        gs_req = 1'b0;
        rst_n  = 1'b1;
        #4;
        rd_pend = 1'b0;
        exp_rv  = 1'b0;
        wq.delete();
        rq.delete();
    endtask

    // Runs from a fresh reset, so the camera must win the first tie.
    task automatic test_tie();
        logic e_c, e_g, e_acc;
        for (int c = 0; c <= 42; c++) begin
            drive_edge();
            cam_req = (c <= 40);
            gs_req  = (c <= 40);
            e_c = (c >= 1 && c <= 16) || (c >= 33 && c <= 41);
            e_g = (c >= 17 && c <= 32);
            if (e_c) begin
                cam_addr  = 16'h2000 + 16'(c);
                cam_wdata = 8'(c);
            end
            if (e_g) gs_addr = 16'h3000 + 16'(c * 3);
            e_acc = (e_c && cam_req) || (e_g && gs_req);
            if (e_acc && e_c) wq.push_back({cam_addr, cam_wdata});
            if (e_acc && e_g) rq.push_back(mem_f(gs_addr));
            #4;
            n_vec++;
            if (cam_gnt !== e_c || gs_gnt !== e_g) begin
                n_err++;
                $display("FAIL tie_gnt c=%0d: got cam=%b gs=%b want cam=%b gs=%b", c, cam_gnt, gs_gnt, e_c, e_g);
            end
            n_vec++;
            if (mem_en !== e_acc || mem_we !== (e_acc && e_c)) begin
                n_err++;
                $display("FAIL tie_en c=%0d: en=%b we=%b want en=%b we=%b", c, mem_en, mem_we, e_acc, e_acc && e_c);
            end
            n_vec++;
            if (gs_rvalid !== exp_rv) begin
                n_err++;
                $display("FAIL tie_rv c=%0d: got %b want %b", c, gs_rvalid, exp_rv);
            end
            if (mem_en && mem_we) begin
                n_vec++;
                if (wq.size() == 0 || {mem_addr, mem_wdata} !== wq[0]) begin
                    n_err++;
                    $display("FAIL tie_wr c=%0d: got %h/%h", c, mem_addr, mem_wdata);
                end
                if (wq.size() != 0) void'(wq.pop_front());
            end
            if (gs_rvalid) begin
                n_vec++;
                if (rq.size() == 0 || gs_rdata !== rq[0]) begin
                    n_err++;
                    $display("FAIL tie_rd c=%0d: got %h", c, gs_rdata);
                end
                if (rq.size() != 0) void'(rq.pop_front());
            end
            exp_rv  = e_acc && e_g;
            rd_pend = mem_en && !mem_we;
            rd_addr = mem_addr;
        end
        n_vec++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_err++;
            $display("FAIL tie_left: %0d writes %0d reads outstanding want 0 0", wq.size(), rq.size());
        end
        wq.delete();
        rq.delete();
    endtask

    // Owner drops while the other side waits: direct handover, no IDLE cycle.
    task automatic test_handover();
        logic e_c, e_g, e_acc;
        ho_tbl = '{4'b1000, 4'b1010, 4'b1110, 4'b1110, 4'b0110, 4'b0101,
                   4'b0101, 4'b1001, 4'b1010, 4'b1010, 4'b0010, 4'b0000};
        for (int c = 0; c < 12; c++) begin
            drive_edge();
            cam_req = ho_tbl[c][3];
            gs_req  = ho_tbl[c][2];
            e_c     = ho_tbl[c][1];
            e_g     = ho_tbl[c][0];
            if (e_c) begin
                cam_addr  = 16'h4000 + 16'(c);
                cam_wdata = 8'(8'h40 + c);
            end
            if (e_g) gs_addr = 16'h5000 + 16'(c);
            e_acc = (e_c && cam_req) || (e_g && gs_req);
            if (e_acc && e_c) wq.push_back({cam_addr, cam_wdata});
            if (e_acc && e_g) rq.push_back(mem_f(gs_addr));
            #4;
            n_vec++;
            if (cam_gnt !== e_c || gs_gnt !== e_g) begin
                n_err++;
                $display("FAIL handover_gnt c=%0d: got cam=%b gs=%b want cam=%b gs=%b", c, cam_gnt, gs_gnt, e_c, e_g);
            end
            n_vec++;
            if (mem_en !== e_acc || mem_we !== (e_acc && e_c)) begin
                n_err++;
                $display("FAIL handover_en c=%0d: en=%b we=%b want en=%b", c, mem_en, mem_we, e_acc);
            end
            n_vec++;
            if (gs_rvalid !== exp_rv) begin
                n_err++;
                $display("FAIL handover_rv c=%0d: got %b want %b", c, gs_rvalid, exp_rv);
            end
            if (mem_en && mem_we) begin
                n_vec++;
                if (wq.size() == 0 || {mem_addr, mem_wdata} !== wq[0]) begin
                    n_err++;
                    $display("FAIL handover_wr c=%0d: got %h/%h", c, mem_addr, mem_wdata);
                end
                if (wq.size() != 0) void'(wq.pop_front());
            end
            if (gs_rvalid) begin
                n_vec++;
                if (rq.size() == 0 || gs_rdata !== rq[0]) begin
                    n_err++;
                    $display("FAIL handover_rd c=%0d: got %h", c, gs_rdata);
                end
                if (rq.size() != 0) void'(rq.pop_front());
            end
            exp_rv  = e_acc && e_g;
            rd_pend = mem_en && !mem_we;
            rd_addr = mem_addr;
        end
        wq.delete();
        rq.delete();
    endtask

    // Competitor arrives after the camera's counter has saturated: the
    // camera gets exactly one more access before the Grayscaler takes over.
    task automatic test_late_contender();
        logic e_c, e_g, e_acc;
        for (int c = 0; c <= 25; c++) begin
            drive_edge();
            cam_req = (c <= 21);
            gs_req  = (c >= 21 && c <= 23);
            e_c = (c >= 1 && c <= 21);
            e_g = (c >= 22 && c <= 24);
            if (e_c) begin
                cam_addr  = 16'h6000 + 16'(c);
                cam_wdata = 8'(c * 5);
            end
            if (c == 21 || e_g) gs_addr = 16'h7000 + 16'(c);
            e_acc = (e_c && cam_req) || (e_g && gs_req);
            #4;
            n_vec++;
            if (cam_gnt !== e_c || gs_gnt !== e_g) begin
                n_err++;
                $display("FAIL late_gnt c=%0d: got cam=%b gs=%b want cam=%b gs=%b", c, cam_gnt, gs_gnt, e_c, e_g);
            end
            n_vec++;
            if (mem_en !== e_acc || mem_we !== (e_acc && e_c)) begin
                n_err++;
                $display("FAIL late_en c=%0d: en=%b we=%b want en=%b", c, mem_en, mem_we, e_acc);
            end
            n_vec++;
            if (gs_rvalid !== exp_rv) begin
                n_err++;
                $display("FAIL late_rv c=%0d: got %b want %b", c, gs_rvalid, exp_rv);
            end
            exp_rv  = e_acc && e_g;
            rd_pend = mem_en && !mem_we;
            rd_addr = mem_addr;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want bench to finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lone_cam();
        test_lone_read();
        test_reset_mid_burst();
        test_tie();
        test_handover();
        test_late_contender();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
